// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cond_pkg
//  Description : Condition codes, opcode classes, sequencer state encoding and
//                the shared taken/not-taken evaluator. COND_SEQ_HALT_EN adds
//                the S_HALT state.
//  Revision    : 1.0 - initial release
// ============================================================================
package cond_pkg;

    localparam logic [2:0] NEVER  = 3'b000;
    localparam logic [2:0] EQ     = 3'b001;
    localparam logic [2:0] LT     = 3'b010;
    localparam logic [2:0] LE     = 3'b011;
    localparam logic [2:0] ALWAYS = 3'b100;
    localparam logic [2:0] NE     = 3'b101;
    localparam logic [2:0] GE     = 3'b110;
    localparam logic [2:0] GT     = 3'b111;

    localparam logic [7:0] ANCHOR = 8'hF0;

    localparam logic [1:0] CLASS_ALU  = 2'b00;
    localparam logic [1:0] CLASS_MEM  = 2'b01;
    localparam logic [1:0] CLASS_IO   = 2'b10;
    localparam logic [1:0] CLASS_COND = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_COND  = 2'd2
`ifdef COND_SEQ_HALT_EN
        ,
        S_HALT  = 2'd3
`endif
    } seq_state_t;

    // Unsigned comparison of the operand against the fixed anchor value.
    function automatic logic cond_eval(input logic [2:0] code, input logic [7:0] operand);
        logic result;
        result = 1'b0;
        case (code)
            NEVER:   result = 1'b0;
            EQ:      result = (operand == ANCHOR);
            LT:      result = (operand <  ANCHOR);
            LE:      result = (operand <= ANCHOR);
            ALWAYS:  result = 1'b1;
            NE:      result = (operand != ANCHOR);
            GE:      result = (operand >= ANCHOR);
            GT:      result = (operand >  ANCHOR);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_fetch_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : cond_fetch_seq_if
//  Description : Program-memory fetch and execute-issue handshake bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cond_fetch_seq_if #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_valid;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid,
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid,
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/cond_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cond_fetch_seq
//  Description : PC owner / fetch-issue sequencer; resolves condition-class
//                jumps locally. COND_SEQ_HALT_EN enables halt on self-jump.
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_fetch_seq
    import cond_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    cond_fetch_seq_if.master       bus,
    input  wire logic [DATA_W-1:0] reg_0,
    input  wire logic [DATA_W-1:0] reg_3,
    output logic [2:0]             arbiter_order,
    output logic                   arbiter_sel,
    output logic [PC_W-1:0]        pc,
    output logic                   halted
);

    localparam logic [PC_W-1:0] c_pc_one = PC_W'(1);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_next_pc;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] w_next_instr;
    logic              w_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_instr <= '0;
        end else begin
            r_pc    <= w_next_pc;
            r_instr <= w_next_instr;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_instr = r_instr;
        w_taken      = cond_eval(r_instr[2:0], reg_3);

        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        arbiter_sel     = 1'b0;
        arbiter_order   = NEVER;
        halted          = 1'b0;

        case (r_state)
            S_FETCH: begin
                bus.imem_req = ~rst;
                if (bus.imem_valid) begin
                    w_next_instr = bus.imem_rdata;
                    w_next_state = (bus.imem_rdata[7:6] == CLASS_COND) ? S_COND : S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.instr_valid = ~rst;
                if (bus.instr_ready) begin
                    w_next_pc    = r_pc + c_pc_one;
                    w_next_state = S_FETCH;
                end
            end
            S_COND: begin
                arbiter_sel   = ~rst;
                arbiter_order = rst ? NEVER : r_instr[2:0];
                w_next_pc     = w_taken ? reg_0 : r_pc + c_pc_one;
                w_next_state  = S_FETCH;
`ifdef COND_SEQ_HALT_EN
                // A taken jump onto itself can never make progress; park here.
                if (w_taken && (reg_0 == r_pc)) begin
                    w_next_state = S_HALT;
                end
`endif
            end
`ifdef COND_SEQ_HALT_EN
            S_HALT: begin
                halted = ~rst;
            end
`endif
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    assign bus.imem_addr = r_pc;
    assign bus.instr     = r_instr;
    assign pc            = r_pc;

endmodule
`default_nettype wire

// File: doc/cond_fetch_seq.md
# cond_fetch_seq

Fetch/branch sequencer for the 8-bit CPU. It owns the program counter, fetches instruction bytes from program memory and hands non-condition instructions to the execute stage. For condition-class instructions it drives `arbiter_order`/`arbiter_sel` toward the bus arbiter, resolves the jump itself, and loads `reg_0` into the PC when the jump is taken.

## Interface
Parameters:
- `PC_W`, 8, program counter and memory address width
- `DATA_W`, 8, instruction and register width

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  PC_W  fetch address (always equals `pc`)
- `imem_rdata`  in  DATA_W  fetched byte, valid with `imem_valid`
- `imem_valid`  in  1  memory response strobe; may stall any number of cycles
- `instr`  out  DATA_W  instruction presented to execute
- `instr_valid`  out  1  `instr` is valid
- `instr_ready`  in  1  execute accepts `instr`
- `reg_0`  in  DATA_W  jump target
- `reg_3`  in  DATA_W  condition operand
- `arbiter_order`  out  3  condition code for the bus arbiter
- `arbiter_sel`  out  1  arbiter drive enable
- `pc`  out  PC_W  current program counter
- `halted`  out  1  sequencer stopped (only with `COND_SEQ_HALT_EN`)

## Operation
- Opcode class is `instr[7:6]`. Classes 00, 01 and 10 are passed to execute. Class 11 is a condition instruction; its condition code is `instr[2:0]`.
- Condition codes:
  - 000 never
  - 001 eq
  - 010 lt
  - 011 le
  - 100 always
  - 101 ne
  - 110 ge
  - 111 gt
- Every condition compares `reg_3` against ANCHOR = 8'hF0, unsigned. Example: eq is true when `reg_3` == 8'hF0.
- `taken = cond_eval(code, reg_3)`.
- FSM states:
  - **S_FETCH:** `imem_req`=1. On `imem_valid`, latch `imem_rdata` into the instruction register. Class 11 goes to S_COND; all other classes go to S_ISSUE. Without `imem_valid`, stay in S_FETCH.
  - **S_ISSUE:** `instr_valid`=1 and `instr` is held stable. On `instr_ready`: `pc <= pc+1`, then go to S_FETCH.
  - **S_COND:** lasts exactly one cycle. `arbiter_sel`=1 and `arbiter_order=instr[2:0]`. Update `pc <= taken ? reg_0 : pc+1`, then go to S_FETCH. Condition instructions never assert `instr_valid`.
  - **S_HALT:** exists only with the macro; see Configuration.
- `pc+1` wraps: 8'hFF becomes 8'h00.
- `imem_valid` is ignored outside S_FETCH.
- Outside S_COND: `arbiter_sel`=0 and `arbiter_order`=000 (never).

## Timing
- Reset values:
  - `pc`=0, state S_FETCH
  - `imem_req`=0 during the reset cycle
  - `instr`=0, `instr_valid`=0
  - `arbiter_sel`=0, `arbiter_order`=000
  - `halted`=0
- Reset during any state discards the latched instruction and any pending fetch. Fetch restarts at address 0 in the first cycle after `rst` deasserts.
- With zero-wait memory and `instr_ready` high, every instruction takes 2 cycles (fetch + issue/cond).
- `instr_valid` stays high until it is accepted. `instr` must not change while `instr_valid`=1 and `instr_ready`=0.
- `reg_0` and `reg_3` are sampled in the S_COND cycle only. The new PC appears on `imem_addr` in the next cycle.

## Configuration
- `COND_SEQ_HALT_EN` defined: a taken condition whose target `reg_0` equals the current `pc` moves the FSM to S_HALT.
  - In S_HALT: `halted`=1, `imem_req`=0, `instr_valid`=0.
  - S_HALT is left only by `rst`.
- `COND_SEQ_HALT_EN` undefined: no S_HALT state. `halted` is tied to 0 and self-jumps re-fetch forever.

## Structure
- Shared package `cond_pkg` holds:
  - the condition-code localparams (NEVER..GT)
  - ANCHOR = 8'hF0
  - opcode class constants
  - the FSM state encoding
  - the function `cond_eval(code, operand)`
- The bus arbiter uses the same package, so both blocks decide "taken" identically.
- No sub-module; a single module plus the package function.

## Test plan
- Reset with `rst` held 2 cycles, then released → `pc`=0, first `imem_req`=1 with `imem_addr`=8'h00, `arbiter_sel`=0.
- Fetch 8'h05; `imem_valid` delayed 2 cycles; `instr_ready` low for 3 cycles → `instr_valid`=1 and `instr`=8'h05 held stable, `pc`=0 throughout; then `instr_ready`=1 → `pc`=1.
- Fetch 8'hC1 with `reg_3`=8'hF0, `reg_0`=8'h20 → one cycle of `arbiter_sel`=1 / `arbiter_order`=001, then `imem_addr`=8'h20, no `instr_valid`.
- Fetch 8'hC2 with `reg_3`=8'hF0 → not taken, `pc` advances by 1. Same case with 8'hC7 and `reg_3`=8'hF1 → taken.
- `pc`=8'hFF issues a class-00 instruction → next `imem_addr`=8'h00. Assert `rst` during S_ISSUE → `instr_valid`=0 next cycle, fetch restarts at 0.
- At `pc`=8'h10, fetch 8'hC4 with `reg_0`=8'h10:
  - macro defined → `halted`=1 and no further `imem_req`.
  - macro undefined → `imem_addr`=8'h10 is re-fetched every 2 cycles.
